// File: rtl/osd_stm_capture_if.sv
// Trace capture bus: CPU register writes in, buffered trace events out.
// master: CPU/consumer side.  slave: capture block side.
//   wr_valid/wr_addr/wr_data  register write strobe, select and data
//   trace_valid/id/value      head event of the buffer
//   trace_ready               consumer accepts the head event
//   drop_count                events lost to a full buffer
interface osd_stm_capture_if #(
    parameter int XLEN = 64
);
    logic            wr_valid;
    logic [1:0]      wr_addr;
    logic [31:0]     wr_data;
    logic            trace_valid;
    logic [15:0]     trace_id;
    logic [XLEN-1:0] trace_value;
    logic            trace_ready;
    logic [15:0]     drop_count;

    modport master (
        output wr_valid, wr_addr, wr_data, trace_ready,
        input  trace_valid, trace_id, trace_value, drop_count
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, trace_ready,
        output trace_valid, trace_id, trace_value, drop_count
    );
endinterface

// File: rtl/osd_stm_capture.sv
// Captures CPU trace-register writes into events and buffers them in a FIFO.
// Ports: clk, rst (async active-high), bus (osd_stm_capture_if.slave).
// Params: XLEN (32|64) value width, FIFO_DEPTH (power of two, >= 2).
// Macro OSD_STM_CAPTURE_DROPCNT_EN enables the saturating drop counter.
module osd_stm_capture #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    osd_stm_capture_if.slave   bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        LO_PENDING
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     id_q, id_d;
    logic [31:0]     lo_q, lo_d;
    logic            commit;
    logic [XLEN-1:0] ev_val;

    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     mem_id  [FIFO_DEPTH];
    logic [XLEN-1:0] mem_val [FIFO_DEPTH];
    logic            empty, full, push, pop;

    // Register decode; lo_q is zero whenever IDLE, so a HI write
    // from IDLE naturally commits with a zero low word.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        lo_d    = lo_q;
        commit  = 1'b0;
        ev_val  = '0;
        if (bus.wr_valid) begin
            unique case (bus.wr_addr)
                2'd0: id_d = bus.wr_data[15:0];
                2'd1: begin
                    if (XLEN == 32) begin
                        commit = 1'b1;
                        ev_val = XLEN'(bus.wr_data);
                    end else begin
                        lo_d    = bus.wr_data;
                        state_d = LO_PENDING;
                    end
                end
                2'd2: begin
                    if (XLEN == 64) begin
                        commit  = 1'b1;
                        ev_val  = XLEN'({bus.wr_data, lo_q});
                        lo_d    = '0;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // A full FIFO still takes a commit when the head leaves this cycle.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(FIFO_DEPTH));
        pop     = !empty && bus.trace_ready;
        push    = commit && (!full || pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            id_q     <= '0;
            lo_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            lo_q    <= lo_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage needs no reset: the pointers and occupancy gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr_q]  <= id_q;
            mem_val[wr_ptr_q] <= ev_val;
        end
    end

    assign bus.trace_valid = !empty;
    assign bus.trace_id    = empty ? '0 : mem_id[rd_ptr_q];
    assign bus.trace_value = empty ? '0 : mem_val[rd_ptr_q];

`ifdef OSD_STM_CAPTURE_DROPCNT_EN
    logic [15:0] drop_q, drop_d;
    logic        drop;

    always_comb begin
        drop   = commit && full && !pop;
        drop_d = drop_q;
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.drop_count = drop_q;
`else
    assign bus.drop_count = '0;
`endif

endmodule

// File: tb/tb_osd_stm_capture.sv
// Scoreboard bench for osd_stm_capture: XLEN=64 and XLEN=32 instances.
// Stimulus queues expected events; negedge monitors compare the head.
module tb_osd_stm_capture;

    typedef struct {
        logic [15:0] id;
        logic [63:0] val;
    } ev_t;

`ifdef OSD_STM_CAPTURE_DROPCNT_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    ev_t  q64[$];
    ev_t  q32[$];

    osd_stm_capture_if #(.XLEN(64)) b64 ();
    osd_stm_capture_if #(.XLEN(32)) b32 ();

    osd_stm_capture #(.XLEN(64), .FIFO_DEPTH(4)) u64 (
        .clk (clk),
        .rst (rst),
        .bus (b64)
    );

    osd_stm_capture #(.XLEN(32), .FIFO_DEPTH(4)) u32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] got,
                                logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && b64.trace_valid) begin
            if (q64.size() == 0) begin
                if (b64.trace_ready) begin
                    checks++;
                    $display("FAIL mon64_unexpected: got id %h val %h expected none",
                             b64.trace_id, b64.trace_value);
                end
            end else begin
                chk("mon64_id", 64'(b64.trace_id), 64'(q64[0].id));
                chk("mon64_val", b64.trace_value, q64[0].val);
                if (b64.trace_ready) void'(q64.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b32.trace_valid) begin
            if (q32.size() == 0) begin
                if (b32.trace_ready) begin
                    checks++;
                    $display("FAIL mon32_unexpected: got id %h val %h expected none",
                             b32.trace_id, b32.trace_value);
                end
            end else begin
                chk("mon32_id", 64'(b32.trace_id), 64'(q32[0].id));
                chk("mon32_val", 64'(b32.trace_value), q32[0].val);
                if (b32.trace_ready) void'(q32.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic w64(input logic [1:0] a, input logic [31:0] d);
        b64.wr_valid = 1'b1;
        b64.wr_addr  = a;
        b64.wr_data  = d;
        cyc();
        b64.wr_valid = 1'b0;
    endtask

    task automatic w32(input logic [1:0] a, input logic [31:0] d);
        b32.wr_valid = 1'b1;
        b32.wr_addr  = a;
        b32.wr_data  = d;
        cyc();
        b32.wr_valid = 1'b0;
    endtask

    task automatic e64(input logic [15:0] id, input logic [63:0] v);
        ev_t e;
        e.id  = id;
        e.val = v;
        q64.push_back(e);
    endtask

    task automatic e32(input logic [15:0] id, input logic [31:0] v);
        ev_t e;
        e.id  = id;
        e.val = {32'h0, v};
        q32.push_back(e);
    endtask

    task automatic drain64(input int budget);
        int n = 0;
        while ((q64.size() != 0 || b64.trace_valid) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain64_done", 64'(q64.size() == 0 && !b64.trace_valid), 64'd1);
    endtask

    task automatic drain32(input int budget);
        int n = 0;
        while ((q32.size() != 0 || b32.trace_valid) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain32_done", 64'(q32.size() == 0 && !b32.trace_valid), 64'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst64_valid", 64'(b64.trace_valid), 64'd0);
        chk("rst64_id", 64'(b64.trace_id), 64'd0);
        chk("rst64_val", b64.trace_value, 64'd0);
        chk("rst64_drop", 64'(b64.drop_count), 64'd0);
        chk("rst32_valid", 64'(b32.trace_valid), 64'd0);
        chk("rst32_id", 64'(b32.trace_id), 64'd0);
        chk("rst32_val", 64'(b32.trace_value), 64'd0);
        chk("rst32_drop", 64'(b32.drop_count), 64'd0);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        b64.wr_valid = 1'b0; b64.wr_addr = '0; b64.wr_data = '0;
        b64.trace_ready = 1'b0;
        b32.wr_valid = 1'b0; b32.wr_addr = '0; b32.wr_data = '0;
        b32.trace_ready = 1'b0;
        repeat (2) cyc();
        chk_reset_outputs();
        rst = 1'b0;
        cyc();

        // 64-bit basic event and one-cycle latency
        b64.trace_ready = 1'b1;
        w64(2'd0, 32'h0000_0042);
        w64(2'd1, 32'hDEAD_BEEF);
        chk("lat_before", 64'(b64.trace_valid), 64'd0);
        e64(16'h0042, 64'h01234567_DEADBEEF);
        w64(2'd2, 32'h0123_4567);
        chk("lat_after", 64'(b64.trace_valid), 64'd1);
        // HI from IDLE, LO overwrite, ID while pending, reserved write
        e64(16'h0042, 64'h00000005_00000000);
        w64(2'd2, 32'h0000_0005);
        w64(2'd1, 32'h0000_0001);
        w64(2'd1, 32'h0000_0002);
        e64(16'h0042, 64'h00000003_00000002);
        w64(2'd2, 32'h0000_0003);
        w64(2'd1, 32'h0000_0011);
        w64(2'd0, 32'h0000_0099);
        e64(16'h0099, 64'h00000022_00000011);
        w64(2'd2, 32'h0000_0022);
        w64(2'd1, 32'h0000_0055);
        w64(2'd3, 32'hFFFF_FFFF);
        e64(16'h0099, 64'h00000066_00000055);
        w64(2'd2, 32'h0000_0066);
        drain64(20);

        // 32-bit: HI ignored, then back-to-back LO commits
        b32.trace_ready = 1'b1;
        w32(2'd2, 32'h1234_5678);
        repeat (3) cyc();
        chk("hi32_ignored", 64'(b32.trace_valid), 64'd0);
        w32(2'd0, 32'h0000_0007);
        for (int v = 1; v <= 3; v++) begin
            e32(16'h0007, 32'(v));
            w32(2'd1, 32'(v));
        end
        drain32(20);

        // Overflow: six commits into four entries
        b32.trace_ready = 1'b0;
        w32(2'd0, 32'h0000_0008);
        for (int v = 10; v < 16; v++) begin
            if (v < 14) e32(16'h0008, 32'(v));
            w32(2'd1, 32'(v));
        end
        cyc();
        chk("drop_six", 64'(b32.drop_count), DC ? 64'd2 : 64'd0);
        // Full with pop and commit in the same cycle
        b32.trace_ready = 1'b1;
        e32(16'h0008, 32'd16);
        b32.wr_valid = 1'b1;
        b32.wr_addr  = 2'd1;
        b32.wr_data  = 32'd16;
        cyc();
        b32.wr_valid    = 1'b0;
        b32.trace_ready = 1'b0;
        chk("drop_popcommit", 64'(b32.drop_count), DC ? 64'd2 : 64'd0);
        w32(2'd1, 32'd17);
        chk("drop_still_full", 64'(b32.drop_count), DC ? 64'd3 : 64'd0);
        b32.trace_ready = 1'b1;
        drain32(20);

        // Reset mid-operation discards buffered and pending data
        b64.trace_ready = 1'b0;
        w64(2'd2, 32'h0000_0077);
        w64(2'd1, 32'hAAAA_0000);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        cyc();
        rst = 1'b0;
        cyc();
        b64.trace_ready = 1'b1;
        e64(16'h0000, 64'h00000001_00000000);
        w64(2'd2, 32'h0000_0001);
        drain64(20);

`ifdef OSD_STM_CAPTURE_DROPCNT_EN
        // Drop counter saturation
        b32.trace_ready = 1'b0;
        w32(2'd0, 32'h0000_0005);
        for (int v = 100; v < 104; v++) begin
            e32(16'h0005, 32'(v));
            w32(2'd1, 32'(v));
        end
        b32.wr_valid = 1'b1;
        b32.wr_addr  = 2'd1;
        b32.wr_data  = 32'd200;
        repeat (65534) cyc();
        chk("drop_fffe", 64'(b32.drop_count), 64'hFFFE);
        repeat (3) cyc();
        chk("drop_sat", 64'(b32.drop_count), 64'hFFFF);
        b32.wr_valid    = 1'b0;
        b32.trace_ready = 1'b1;
        drain32(20);
`endif

        repeat (2) cyc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/osd_stm_capture.md
OSD_STM_CAPTURE -- requirements
Module: osd_stm_capture

Interface
REQ-001 SHALL have parameter XLEN, default 64, trace value width; legal values 32 and 64.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, event buffer entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wr_valid, input, 1, CPU trace-register write strobe, always accepted.
REQ-006 SHALL have port wr_addr, input, 2, register select: 0=ID, 1=VALUE_LO, 2=VALUE_HI, 3=reserved.
REQ-007 SHALL have port wr_data, input, 32, write data.
REQ-008 SHALL have port trace_valid, output, 1, buffered event available; connects to osd_stm trace_valid.
REQ-009 SHALL have port trace_id, output, 16, event id of head entry.
REQ-010 SHALL have port trace_value, output, XLEN, event value of head entry.
REQ-011 SHALL have port trace_ready, input, 1, consumer accepts head entry; tied high when driving osd_stm.
REQ-012 SHALL have port drop_count, output, 16, events lost to a full buffer.

Function
REQ-013 SHALL latch wr_data[15:0] into a sticky id register on an ID write; the register holds until the next ID write.
REQ-014 SHALL, for XLEN=32, commit event {id_reg, wr_data} on a VALUE_LO write.
REQ-015 SHALL, for XLEN=64, latch wr_data into lo_reg on a VALUE_LO write and enter state LO_PENDING.
REQ-016 SHALL, for XLEN=64, commit event {id_reg, {wr_data, lo_reg}} on a VALUE_HI write, clear lo_reg to 0 and return to IDLE.
REQ-017 SHALL treat a VALUE_HI write in IDLE as a commit with low word 0.
REQ-018 SHALL make a second VALUE_LO write in LO_PENDING overwrite lo_reg, with no commit.
REQ-019 SHALL ignore VALUE_HI writes when XLEN=32.
REQ-020 SHALL ignore reserved-address writes, with no state change.
REQ-021 SHALL keep state LO_PENDING across an ID write; the commit uses the new id.
REQ-022 SHALL push the committed event into the FIFO in the write cycle; trace_valid asserts the next cycle (latency 1).
REQ-023 SHALL drive trace_valid high exactly while the FIFO is non-empty, and trace_id/trace_value from the head entry.
REQ-024 SHALL pop the head when trace_valid and trace_ready are both high at a rising edge.
REQ-025 SHALL preserve FIFO order; the read and write pointers wrap modulo FIFO_DEPTH.
REQ-026 SHALL accept a commit to a full FIFO if a pop occurs in the same cycle.
REQ-027 SHALL otherwise drop a commit to a full FIFO, with the FIFO contents unchanged.
REQ-028 SHALL accept push and pop in the same cycle on a non-empty FIFO, leaving the occupancy unchanged.
REQ-029 SHALL hold trace_id/trace_value stable while trace_valid is high and trace_ready is low.

Reset
REQ-030 SHALL, on rst, asynchronously clear id_reg, lo_reg, the FIFO pointers and occupancy, and drop_count, and set state IDLE.
REQ-031 SHALL hold trace_valid=0, trace_id=0, trace_value=0 and drop_count=0 while rst is high.
REQ-032 SHALL discard all buffered events and any pending low word when rst asserts mid-operation; no partial event is emitted after release.

Configuration
REQ-033 SHALL, when macro OSD_STM_CAPTURE_DROPCNT_EN is defined, increment drop_count on each dropped commit, saturating at 16'hFFFF.
REQ-034 SHALL, when OSD_STM_CAPTURE_DROPCNT_EN is undefined, tie drop_count to 0 and instantiate no counter logic; drop behaviour is otherwise unchanged.

Verification
REQ-035 SHALL verify this scenario: XLEN=64; write ID=16'h0042, LO=32'hDEADBEEF, HI=32'h01234567 -> one cycle later trace_valid=1, trace_id=16'h0042, trace_value=64'h01234567DEADBEEF.
REQ-036 SHALL verify this scenario: XLEN=32; ID=16'h0007, then LO writes 1, 2, 3 on back-to-back cycles, trace_ready=1 -> three events, id 7, values 1, 2, 3, in order.
REQ-037 SHALL verify this scenario: FIFO_DEPTH=4; trace_ready=0; six commits -> four entries held, drop_count=2 with macro, 0 without; releasing ready yields the first four values.
REQ-038 SHALL verify this scenario: FIFO full, trace_ready=1 and a commit in the same cycle -> commit accepted, drop_count unchanged, occupancy stays 4.
REQ-039 SHALL verify this scenario: XLEN=64; LO=32'hAAAA0000, then rst pulse, then HI=32'h00000001 -> event value 64'h0000000100000000, id 0.
REQ-040 SHALL verify this scenario: with the macro defined, force 65537 drops -> drop_count saturates at 16'hFFFF.
